segment_display: RTL and testbench



---
 rtl/segment_display_if.sv | 25 ++
 rtl/segment_display.sv | 95 +++++++++
 tb/tb_segment_display.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/segment_display_if.sv
// Digit inputs and segment/select outputs of the two-digit seven-segment driver.
// Names follow the board connector: A0..A6 are segments a..g, A7 is the decimal point.
interface segment_display_if;
    logic [3:0] D_0;
    logic [3:0] D_1;
    logic       A0;
    logic       A1;
    logic       A2;
    logic       A3;
    logic       A4;
    logic       A5;
    logic       A6;
    logic       A7;
    logic       cathode;

    modport master (
        output D_0, D_1,
        input  A0, A1, A2, A3, A4, A5, A6, A7, cathode
    );

    modport slave (
        input  D_0, D_1,
        output A0, A1, A2, A3, A4, A5, A6, A7, cathode
    );
endinterface

// File: rtl/segment_display.sv
// Two-digit multiplexed seven-segment driver (common cathode, shared segment bus).
// Alternates between D_0 and D_1 every REFRESH_DIV clocks; all outputs are registered.
//
// state | meaning
// DIG0  | cathode=0, segments show decode(D_0)
// DIG1  | cathode=1, segments show decode(D_1)
module segment_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic              clock,
    input  logic              reset,
    segment_display_if.slave  disp
);

    typedef enum logic {
        DIG0 = 1'b0,
        DIG1 = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [6:0]       seg;
    logic [6:0]       seg_next;
    logic [3:0]       digit_sel;
    logic             terminal;

    function automatic logic [6:0] hex_decode(input logic [3:0] hex);
        logic [6:0] pattern;
        unique case (hex)
            4'h0: pattern = 7'h3F;
            4'h1: pattern = 7'h06;
            4'h2: pattern = 7'h5B;
            4'h3: pattern = 7'h4F;
            4'h4: pattern = 7'h66;
            4'h5: pattern = 7'h6D;
            4'h6: pattern = 7'h7D;
            4'h7: pattern = 7'h07;
            4'h8: pattern = 7'h7F;
            4'h9: pattern = 7'h6F;
            4'hA: pattern = 7'h77;
            4'hB: pattern = 7'h7C;
            4'hC: pattern = 7'h39;
            4'hD: pattern = 7'h5E;
            4'hE: pattern = 7'h79;
            default: pattern = 7'h71;
        endcase
        return pattern;
    endfunction

    // Reset wins over a coincident terminal count: the phase always restarts at digit 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DIG0;
            cnt   <= '0;
            seg   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            seg   <= seg_next;
        end
    end

    always_comb begin
        terminal   = (cnt == CNT_LAST);
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        if (terminal) begin
            cnt_next   = '0;
            state_next = (state == DIG0) ? DIG1 : DIG0;
        end
    end

    // Segments follow the select value being loaded on the same edge, so the
    // bus and the digit line never disagree.
    always_comb begin
        digit_sel = (state_next == DIG1) ? disp.D_1 : disp.D_0;
        seg_next  = hex_decode(digit_sel);
    end

    assign disp.A0      = seg[0];
    assign disp.A1      = seg[1];
    assign disp.A2      = seg[2];
    assign disp.A3      = seg[3];
    assign disp.A4      = seg[4];
    assign disp.A5      = seg[5];
    assign disp.A6      = seg[6];
    assign disp.A7      = 1'b0;
    assign disp.cathode = (state == DIG1);

endmodule

// File: tb/tb_segment_display.sv
// Directed bench for segment_display: a fast instance (REFRESH_DIV=4) for phase
// behaviour and a slow instance (REFRESH_DIV=64) for the full decode sweep.
module tb_segment_display;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    segment_display_if dif_fast ();
    segment_display_if dif_slow ();

    segment_display #(.REFRESH_DIV(4), .CNT_W(3)) dut_fast (
        .clock (clock),
        .reset (reset),
        .disp  (dif_fast)
    );

    segment_display #(.REFRESH_DIV(64), .CNT_W(7)) dut_slow (
        .clock (clock),
        .reset (reset),
        .disp  (dif_slow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] fast_seg();
        return {dif_fast.A7, dif_fast.A6, dif_fast.A5, dif_fast.A4,
                dif_fast.A3, dif_fast.A2, dif_fast.A1, dif_fast.A0};
    endfunction

    function automatic logic [7:0] slow_seg();
        return {dif_slow.A7, dif_slow.A6, dif_slow.A5, dif_slow.A4,
                dif_slow.A3, dif_slow.A2, dif_slow.A1, dif_slow.A0};
    endfunction

    task automatic check_fast(input string tag, input logic [7:0] exp_seg, input logic exp_cath);
        check({tag, " seg"}, fast_seg(), exp_seg);
        check({tag, " cathode"}, {7'd0, dif_fast.cathode}, {7'd0, exp_cath});
    endtask

    initial begin
        logic [7:0] hex_table [16];
        checks = 0;
        errors = 0;
        hex_table = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

        // Reset hold: dark display, digit 0 selected.
        reset = 1'b1;
        dif_fast.D_0 = 4'h3;
        dif_fast.D_1 = 4'h7;
        dif_slow.D_0 = 4'h3;
        dif_slow.D_1 = 4'h7;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_fast("reset_hold", 8'h00, 1'b0);
            check("reset_hold slow", slow_seg(), 8'h00);
        end

        // Release and decode: toggles at edges 4 and 8 after release.
        dif_fast.D_0 = 4'h1;
        dif_fast.D_1 = 4'h0;
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e >= 4 && e < 8) check_fast($sformatf("release e%0d", e), 8'h3F, 1'b1);
            else                 check_fast($sformatf("release e%0d", e), 8'h06, 1'b0);
        end

        // Live update of the selected digit (cnt now 0, cathode 0).
        dif_fast.D_0 = 4'h0;
        tick();
        check_fast("live d0=0", 8'h3F, 1'b0);
        dif_fast.D_0 = 4'h1;
        tick();
        check_fast("live d0=1", 8'h06, 1'b0);

        // Deselected update: D_1 change only shows at the toggle edge.
        dif_fast.D_1 = 4'h2;
        tick();
        check_fast("desel hold", 8'h06, 1'b0);
        tick();
        check_fast("desel toggle", 8'h5B, 1'b1);

        // Mid-period reset with cathode=1 and cnt=2.
        tick();
        tick();
        check_fast("pre_reset", 8'h5B, 1'b1);
        reset = 1'b1;
        tick();
        check_fast("mid_reset", 8'h00, 1'b0);
        reset = 1'b0;
        dif_fast.D_0 = 4'h5;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 4) check_fast("after_reset e4", 8'h5B, 1'b1);
            else        check_fast($sformatf("after_reset e%0d", e), 8'h6D, 1'b0);
        end

        // Reset coinciding with a terminal count (cnt=3, cathode=1).
        tick();
        tick();
        tick();
        check_fast("pre_term_reset", 8'h5B, 1'b1);
        reset = 1'b1;
        tick();
        check_fast("term_reset", 8'h00, 1'b0);
        reset = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 4) check_fast("term_release e4", 8'h5B, 1'b1);
            else        check_fast($sformatf("term_release e%0d", e), 8'h6D, 1'b0);
        end

        // Full decode sweep on the slow instance while digit 0 stays selected.
        reset = 1'b1;
        dif_slow.D_1 = 4'h8;
        tick();
        check("sweep reset", slow_seg(), 8'h00);
        reset = 1'b0;
        for (int d = 0; d < 16; d++) begin
            dif_slow.D_0 = 4'(d);
            tick();
            check($sformatf("sweep hex %0h", d), slow_seg(), hex_table[d]);
            check($sformatf("sweep cathode %0h", d), {7'd0, dif_slow.cathode}, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
